// File: rtl/mix_columns_engine.sv
// Sequential AES MixColumns / InvMixColumns engine, COLS_PER_CYCLE columns per clock over valid/ready.
// Build option: define MIXCOL_INV_EN to synthesise the inverse path selected by in_inverse.
//
// state | meaning
// IDLE  | waiting for an input handshake; in_ready=1
// BUSY  | transforming one column group per clock in the working register
// DONE  | result presented; out_valid held until out_ready
module mix_columns_engine #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         in_inverse,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);
   // Group base is the column index with the in-group offset bits cleared.
   localparam logic [1:0] GRP_MASK = 2'(4 - COLS_PER_CYCLE);

   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_fwd(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] r0, r1, r2, r3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      return {r0, r1, r2, r3};
   endfunction

`ifdef MIXCOL_INV_EN
   // Multiples 9/B/D/E from the x2/x4/x8 chain of each byte.
   function automatic logic [31:0] mix_inv(input logic [31:0] col);
      logic [7:0] a  [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[31 - 8*i -: 8];
         x2    = xtime(a[i]);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[i] = x8 ^ a[i];
         mb[i] = x8 ^ x2 ^ a[i];
         md[i] = x8 ^ x4 ^ a[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   logic mode_inv;
`else
   logic unused_inverse;
   assign unused_inverse = in_inverse;
`endif

   logic [1:0]   state;
   logic [1:0]   cnt;
   logic [127:0] work;
   logic [127:0] work_next;
   logic [31:0]  col_in  [COLS_PER_CYCLE];
   logic [31:0]  col_out [COLS_PER_CYCLE];

   assign in_ready = (state == IDLE);

   always_comb begin
      for (int j = 0; j < COLS_PER_CYCLE; j++) begin
         col_in[j] = work[127 - 32*(int'(cnt) + j) -: 32];
`ifdef MIXCOL_INV_EN
         col_out[j] = mode_inv ? mix_inv(col_in[j]) : mix_fwd(col_in[j]);
`else
         col_out[j] = mix_fwd(col_in[j]);
`endif
      end
      work_next = work;
      for (int c = 0; c < 4; c++) begin
         if ((2'(c) & GRP_MASK) == cnt) begin
            work_next[127 - 32*c -: 32] = col_out[c % COLS_PER_CYCLE];
         end
      end
   end

   // Working register and mode carry no reset: contents are meaningless outside BUSY.
   always_ff @(posedge clk) begin
      if (state == IDLE && in_valid) begin
         work <= in_data;
`ifdef MIXCOL_INV_EN
         mode_inv <= in_inverse;
`endif
      end else if (state == BUSY) begin
         work <= work_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 2'd0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= 2'd0;
               if (in_valid) begin
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (cnt == LAST_CNT) begin
                  state     <= DONE;
                  cnt       <= 2'd0;
                  out_valid <= 1'b1;
                  out_data  <= work_next;
               end else begin
                  cnt <= cnt + STEP;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               cnt       <= 2'd0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
